// File: rtl/bitblaster_pkg.sv
// Shared definitions for the BitBlaster 10-bit processor: ALU function codes,
// instruction prefixes, controller step encoding and decode helpers.
package bitblaster_pkg;

  localparam int BB_DATA_W = 10;
  localparam int BB_NREGS  = 4;

  localparam logic [3:0] FN_LOAD = 4'b0000;
  localparam logic [3:0] FN_COPY = 4'b0001;
  localparam logic [3:0] FN_ADD  = 4'b0010;
  localparam logic [3:0] FN_SUB  = 4'b0011;
  localparam logic [3:0] FN_INV  = 4'b0100;
  localparam logic [3:0] FN_FLIP = 4'b0101;
  localparam logic [3:0] FN_AND  = 4'b0110;
  localparam logic [3:0] FN_OR   = 4'b0111;
  localparam logic [3:0] FN_XOR  = 4'b1000;
  localparam logic [3:0] FN_LSL  = 4'b1001;
  localparam logic [3:0] FN_LSR  = 4'b1010;
  localparam logic [3:0] FN_ASR  = 4'b1011;
  localparam logic [3:0] FN_ADDI = 4'b1100;
  localparam logic [3:0] FN_SUBI = 4'b1101;

  localparam logic [1:0] PFX_REG     = 2'b00;
  localparam logic [1:0] PFX_ILLEGAL = 2'b01;
  localparam logic [1:0] PFX_ADDI    = 2'b10;
  localparam logic [1:0] PFX_SUBI    = 2'b11;

  typedef enum logic [1:0] {T0, T1, T2, T3} t_step;

  // Instruction classes that share an identical step sequence.
  typedef enum logic [2:0] {
    K_LD, K_CP, K_INV, K_FLP, K_ALU, K_IMM, K_ILL
  } t_kind;

  function automatic t_kind decode_kind(input logic [9:0] ir);
    t_kind k;
    k = K_ILL;
    case (ir[9:8])
      PFX_ADDI, PFX_SUBI: k = K_IMM;
      PFX_ILLEGAL:        k = K_ILL;
      default: begin
        case (ir[3:0])
          FN_LOAD: k = K_LD;
          FN_COPY: k = K_CP;
          FN_INV:  k = K_INV;
          FN_FLIP: k = K_FLP;
          FN_ADD, FN_SUB, FN_AND, FN_OR,
          FN_XOR, FN_LSL, FN_LSR, FN_ASR: k = K_ALU;
          default: k = K_ILL;
        endcase
      end
    endcase
    return k;
  endfunction

  function automatic logic [3:0] decode_fn(input logic [9:0] ir);
    logic [3:0] fn;
    case (ir[9:8])
      PFX_REG:  fn = ir[3:0];
      PFX_ADDI: fn = FN_ADDI;
      PFX_SUBI: fn = FN_SUBI;
      default:  fn = 4'b0000;
    endcase
    return fn;
  endfunction

  function automatic t_step last_step(input t_kind k);
    t_step s;
    case (k)
      K_INV:                 s = T2;
      K_FLP, K_ALU, K_IMM:   s = T3;
      default:               s = T1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-bit register index to 4-bit one-hot select, all zero when disabled.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] idx,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_controller.sv
// BitBlaster control sequencer: latches an instruction on Exec and steps
// through T1..T3 issuing register, bus and ALU controls (Moore outputs).
module alu_controller
  import bitblaster_pkg::*;
#(
  parameter int DATA_W = BB_DATA_W,
  parameter int NREGS  = BB_NREGS
) (
  input  logic              CLKb,
  input  logic              Rstb,
  input  logic              Exec,
  input  logic [DATA_W-1:0] INST,
  output logic              IRin,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              ENW,
  output logic              IMMout,
  output logic [DATA_W-1:0] IMM,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [3:0]        FN,
  output logic              Done
);

  t_step             state;
  logic [DATA_W-1:0] ir;
  t_kind             kind;
  t_step             final_step;
  logic [3:0]        fn_dec;
  logic [1:0]        x_idx;
  logic [1:0]        y_idx;
  logic [1:0]        rout_idx;
  logic              rin_en;
  logic              rout_en;

  assign kind       = decode_kind(ir);
  assign final_step = last_step(kind);
  assign fn_dec     = decode_fn(ir);
  assign x_idx      = ir[7:6];
  assign y_idx      = ir[5:4];

  // Step sequencer: Exec only matters in T0; the final step always returns to T0.
  always_ff @(negedge CLKb or negedge Rstb) begin
    if (!Rstb) begin
      state <= T0;
      ir    <= '0;
    end else begin
      case (state)
        T0: begin
          if (Exec) begin
            ir    <= INST;
            state <= T1;
          end
        end
        T1:      state <= (final_step == T1) ? T0 : T2;
        T2:      state <= (final_step == T2) ? T0 : T3;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = y_idx;
    ENW      = 1'b0;
    IMMout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    Done     = 1'b0;
    if (state != T0 && state == final_step) begin
      Done   = 1'b1;
      rin_en = (kind != K_ILL);
    end
    case (kind)
      K_LD: begin
        if (state == T1) ENW = 1'b1;
      end
      K_CP: begin
        if (state == T1) rout_en = 1'b1;
      end
      K_INV: begin
        if (state == T1) begin
          rout_en = 1'b1;
          Gin     = 1'b1;
        end
        if (state == T2) Gout = 1'b1;
      end
      K_FLP: begin
        if (state == T1) begin
          rout_en = 1'b1;
          Ain     = 1'b1;
        end
        if (state == T2) Gin = 1'b1;
        if (state == T3) Gout = 1'b1;
      end
      K_ALU, K_IMM: begin
        // First operand is the destination register; second is Y or the immediate.
        if (state == T1) begin
          rout_en  = 1'b1;
          rout_idx = x_idx;
          Ain      = 1'b1;
        end
        if (state == T2) begin
          Gin = 1'b1;
          if (kind == K_ALU) rout_en = 1'b1;
          else               IMMout  = 1'b1;
        end
        if (state == T3) Gout = 1'b1;
      end
      default: ;
    endcase
  end

  dec2to4 u_rin_dec (
    .en     (rin_en),
    .idx    (x_idx),
    .onehot (Rin)
  );

  dec2to4 u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (Rout)
  );

  assign IRin = (state == T0) && Exec && Rstb;
  assign FN   = (state == T0) ? 4'b0000 : fn_dec;
  assign IMM  = {{(DATA_W-6){1'b0}}, ir[5:0]};

endmodule

// File: tb/tb_alu_controller.sv
// Scoreboard bench for alu_controller: expected output vectors are queued as
// each cycle's stimulus is driven and compared at the following rising edge.
module tb_alu_controller;

  logic       CLKb = 1'b1;
  logic       Rstb = 1'b0;
  logic       Exec = 1'b0;
  logic [9:0] INST = '0;
  logic       IRin;
  logic [3:0] Rin;
  logic [3:0] Rout;
  logic       ENW;
  logic       IMMout;
  logic [9:0] IMM;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] FN;
  logic       Done;

  alu_controller dut (
    .CLKb   (CLKb),
    .Rstb   (Rstb),
    .Exec   (Exec),
    .INST   (INST),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .ENW    (ENW),
    .IMMout (IMMout),
    .IMM    (IMM),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .FN     (FN),
    .Done   (Done)
  );

  always #5 CLKb = ~CLKb;

  int          checks = 0;
  int          fails  = 0;
  logic [28:0] expQ[$];
  string       tagQ[$];
  int          mStep = 0;
  logic [9:0]  mIr   = '0;
  logic [28:0] obs;

  assign obs = {IRin, Rin, Rout, ENW, IMMout, IMM, Ain, Gin, Gout, FN, Done};

  localparam int KLD = 0, KCP = 1, KINV = 2, KFLP = 3, KALU = 4, KIMM = 5, KILL = 6;

  function automatic int kindOf(input logic [9:0] ir);
    if (ir[9:8] == 2'b01) return KILL;
    if (ir[9])            return KIMM;
    if (ir[3:0] >= 4'd12) return KILL;
    if (ir[3:0] == 4'd0)  return KLD;
    if (ir[3:0] == 4'd1)  return KCP;
    if (ir[3:0] == 4'd4)  return KINV;
    if (ir[3:0] == 4'd5)  return KFLP;
    return KALU;
  endfunction

  function automatic int nSteps(input int k);
    if (k == KINV) return 2;
    if (k == KFLP || k == KALU || k == KIMM) return 3;
    return 1;
  endfunction

  // Reference behaviour: one output vector for a given step, IR and Exec/Rstb.
  function automatic logic [28:0] expOut(input int step, input logic [9:0] ir,
                                         input logic ex, input logic rb);
    logic       irin, enw, immo, ain, gin, gout, done;
    logic [3:0] rin, rout, fn, ox, oy;
    int         k;
    int         n;
    irin = 1'b0; enw = 1'b0; immo = 1'b0; ain = 1'b0; gin = 1'b0; gout = 1'b0;
    done = 1'b0; rin = 4'b0; rout = 4'b0; fn = 4'b0;
    ox = 4'b0001 << ir[7:6];
    oy = 4'b0001 << ir[5:4];
    k  = kindOf(ir);
    n  = nSteps(k);
    if (step == 0) begin
      irin = ex & rb;
    end else begin
      case (ir[9:8])
        2'b00:   fn = ir[3:0];
        2'b10:   fn = 4'b1100;
        2'b11:   fn = 4'b1101;
        default: fn = 4'b0000;
      endcase
      if (step == n) begin
        done = 1'b1;
        if (k != KILL) rin = ox;
      end
      case (k)
        KLD: enw = 1'b1;
        KCP: rout = oy;
        KINV: begin
          if (step == 1) begin rout = oy; gin = 1'b1; end
          else gout = 1'b1;
        end
        KFLP: begin
          if (step == 1) begin rout = oy; ain = 1'b1; end
          else if (step == 2) gin = 1'b1;
          else gout = 1'b1;
        end
        KALU, KIMM: begin
          if (step == 1) begin rout = ox; ain = 1'b1; end
          else if (step == 2) begin
            gin = 1'b1;
            if (k == KALU) rout = oy;
            else immo = 1'b1;
          end else gout = 1'b1;
        end
        default: ;
      endcase
    end
    return {irin, rin, rout, enw, immo, {4'b0000, ir[5:0]}, ain, gin, gout, fn, done};
  endfunction

  task automatic checkOutput(input string tag, input logic [28:0] got, input logic [28:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, queue its expected outputs, then compare on the rising edge.
  task automatic applyStimulus(input logic ex, input logic [9:0] inst, input logic rb);
    logic [28:0] e;
    string       t;
    @(negedge CLKb);
    #1;
    Rstb = rb;
    Exec = ex;
    INST = inst;
    if (!rb) begin
      mStep = 0;
      mIr   = '0;
    end
    expQ.push_back(expOut(mStep, mIr, ex, rb));
    tagQ.push_back($sformatf("ir=%h T%0d rst=%0b", mIr, mStep, !rb));
    if (rb) begin
      if (mStep == 0) begin
        if (ex) begin
          mIr   = inst;
          mStep = 1;
        end
      end else if (mStep == nSteps(kindOf(mIr))) begin
        mStep = 0;
      end else begin
        mStep++;
      end
    end
    @(posedge CLKb);
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput(t, obs, e);
  endtask

  task automatic runInstr(input logic [9:0] inst, input logic noisy);
    applyStimulus(1'b1, inst, 1'b1);
    for (int i = 0; i < nSteps(kindOf(inst)); i++)
      applyStimulus(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 10'($urandom), 1'b1);
  endtask

  logic [9:0] directed[12];

  initial begin
    directed[0]  = 10'b00_01_00_0000;
    directed[1]  = 10'b00_10_11_0010;
    directed[2]  = 10'b10_00_101101;
    directed[3]  = 10'b00_11_01_0100;
    directed[4]  = 10'b00_10_00_0101;
    directed[5]  = 10'b01_10_101010;
    directed[6]  = 10'b00_01_01_1110;
    directed[7]  = 10'b00_00_11_0001;
    directed[8]  = 10'b00_01_01_0010;
    directed[9]  = 10'b11_11_111111;
    directed[10] = 10'b00_10_01_1011;
    directed[11] = 10'b00_11_10_0111;

    applyStimulus(1'b0, 10'h000, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1);
    // Reset arrives while an add is in T2.
    applyStimulus(1'b1, 10'b00_10_11_0010, 1'b1);
    applyStimulus(1'b0, 10'h3FF, 1'b1);
    applyStimulus(1'b0, 10'h3FF, 1'b0);
    applyStimulus(1'b0, 10'h000, 1'b1);

    foreach (directed[i]) runInstr(directed[i], 1'b0);

    // Exec during T2 is ignored; the following cp starts back-to-back.
    applyStimulus(1'b1, 10'b00_01_01_0010, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b1);
    applyStimulus(1'b1, 10'b00_11_00_0000, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b1);
    runInstr(10'b00_00_11_0001, 1'b0);
    applyStimulus(1'b0, 10'h155, 1'b1);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, 10'($urandom), 1'b1);
      runInstr(10'($urandom), 1'b1);
    end
    applyStimulus(1'b0, 10'h000, 1'b1);

    checkOutput("scoreboard drained", 29'(expQ.size()), 29'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
